// File: rtl/vc_table_prog.sv
// vc_table_prog: runtime-programmable dest->VC table with a one-stage registered lookup pipeline and a saturating miss counter.
module vc_table_prog #(
  parameter int N = 16,
  parameter int NUM_VC = 2,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int NUM_DEST = 4,
  parameter int IDX_WIDTH = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1,
  parameter int DEST [NUM_DEST] = '{default: 1},
  parameter int VC [NUM_DEST] = '{default: 1},
  parameter int DEFAULT_VC = 0,
  parameter int MISS_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_ADDR_WIDTH-1:0]   in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_ADDR_WIDTH-1:0]   out_dest,
  output logic [VC_ADDR_WIDTH-1:0]  out_vc,
  output logic                      out_hit,
  input  logic                      cfg_wr_en,
  input  logic [IDX_WIDTH-1:0]      cfg_idx,
  input  logic [N_ADDR_WIDTH-1:0]   cfg_dest,
  input  logic [VC_ADDR_WIDTH-1:0]  cfg_vc,
  input  logic                      cfg_entry_valid,
  input  logic                      cfg_clear,
  output logic [MISS_CNT_WIDTH-1:0] miss_count
);
  logic [NUM_DEST-1:0]      valid_q, valid_d;
  logic [N_ADDR_WIDTH-1:0]  dest_q [NUM_DEST];
  logic [N_ADDR_WIDTH-1:0]  dest_d [NUM_DEST];
  logic [VC_ADDR_WIDTH-1:0] vc_q [NUM_DEST];
  logic [VC_ADDR_WIDTH-1:0] vc_d [NUM_DEST];
  logic                      out_valid_q, out_valid_d, out_hit_q, out_hit_d;
  logic [N_ADDR_WIDTH-1:0]   out_dest_q, out_dest_d;
  logic [VC_ADDR_WIDTH-1:0]  out_vc_q, out_vc_d;
  logic [MISS_CNT_WIDTH-1:0] miss_q, miss_d;
  logic                      hit, acc, wr_ok;
  logic [VC_ADDR_WIDTH-1:0]  hit_vc;
  assign in_ready   = !rst && (!out_valid_q || out_ready);
  assign acc        = in_valid && in_ready;
  assign wr_ok      = cfg_wr_en && (int'(cfg_idx) < NUM_DEST);
  assign out_valid  = out_valid_q;
  assign out_dest   = out_dest_q;
  assign out_vc     = out_vc_q;
  assign out_hit    = out_hit_q;
  assign miss_count = miss_q;
  // Scan downwards so the lowest matching index is the last to overwrite.
  always_comb begin
    hit = 1'b0;
    hit_vc = VC_ADDR_WIDTH'(DEFAULT_VC);
    for (int i = NUM_DEST - 1; i >= 0; i--)
      if (valid_q[i] && dest_q[i] == in_dest) begin
        hit = 1'b1;
        hit_vc = vc_q[i];
      end
  end
  always_comb begin
    valid_d = cfg_clear ? '0 : valid_q;
    dest_d = dest_q;
    vc_d = vc_q;
    if (wr_ok) begin
      valid_d[cfg_idx] = cfg_entry_valid;
      dest_d[cfg_idx] = cfg_dest;
      vc_d[cfg_idx] = cfg_vc;
    end
  end
  always_comb begin
    out_valid_d = in_ready ? in_valid : out_valid_q;
    out_dest_d = acc ? in_dest : out_dest_q;
    out_vc_d = acc ? hit_vc : out_vc_q;
    out_hit_d = acc ? hit : out_hit_q;
    miss_d = (acc && !hit && miss_q != '1) ? miss_q + 1'b1 : miss_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '1;
      for (int i = 0; i < NUM_DEST; i++) begin
        dest_q[i] <= N_ADDR_WIDTH'(DEST[i]);
        vc_q[i] <= VC_ADDR_WIDTH'(VC[i]);
      end
      out_valid_q <= 1'b0;
      out_dest_q <= '0;
      out_vc_q <= '0;
      out_hit_q <= 1'b0;
      miss_q <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q <= dest_d;
      vc_q <= vc_d;
      out_valid_q <= out_valid_d;
      out_dest_q <= out_dest_d;
      out_vc_q <= out_vc_d;
      out_hit_q <= out_hit_d;
      miss_q <= miss_d;
    end
  end
endmodule

// File: tb/tb_vc_table_prog.sv
// tb_vc_table_prog: directed scoreboard bench for vc_table_prog (DEFAULT_VC=1, 2-bit miss counter).
module tb_vc_table_prog;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_hit;
  logic [3:0] in_dest = '0, out_dest, cfg_dest = '0;
  logic [0:0] out_vc, cfg_vc = '0;
  logic cfg_wr_en = 1'b0, cfg_entry_valid = 1'b0, cfg_clear = 1'b0;
  logic [1:0] cfg_idx = '0, miss_count;
  logic [5:0] sb [$];
  int n_cmp = 0, n_err = 0;

  vc_table_prog #(
    .DEST('{3, 5, 7, 9}), .VC('{0, 1, 1, 0}), .DEFAULT_VC(1), .MISS_CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest), .out_vc(out_vc),
    .out_hit(out_hit), .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_dest(cfg_dest),
    .cfg_vc(cfg_vc), .cfg_entry_valid(cfg_entry_valid), .cfg_clear(cfg_clear),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] d, input logic vc, input logic hit);
    in_valid = 1'b1;
    in_dest = d;
    sb.push_back({d, vc, hit});
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [3:0] d, input logic vc, input logic v);
    cfg_wr_en = 1'b1;
    cfg_idx = idx;
    cfg_dest = d;
    cfg_vc = vc;
    cfg_entry_valid = v;
  endtask

  // Each negedge with out_valid&out_ready is exactly one output transfer.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [5:0] e;
      e = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
      chk("result", {out_dest, out_vc, out_hit}, e);
    end
  end

  initial begin
    step();
    @(negedge clk);
    chk("in_ready_rst", in_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", {out_dest, out_vc, out_hit}, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    req(5, 1, 1);
    step();
    req(9, 0, 1);
    @(negedge clk);
    chk("latency1", out_valid, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1);
    step();
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    req(2, 1, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("miss_cnt1", miss_count, 1);
    for (int i = 0; i < 4; i++) begin
      req(2, 1, 0);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("miss_sat", miss_count, 3);
    step();
    out_ready = 1'b0;
    req(7, 1, 1);
    step();
    in_dest = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_valid, out_dest, out_vc, out_hit}, {1'b1, 4'd7, 1'b1, 1'b1});
      step();
    end
    out_ready = 1'b1;
    sb.push_back({4'd3, 1'b0, 1'b1});
    @(negedge clk);
    chk("bp_release", in_ready, 1);
    step();
    req(5, 1, 1);
    cfg(1, 5, 0, 1);
    step();
    cfg_wr_en = 1'b0;
    req(5, 0, 1);
    step();
    in_valid = 1'b0;
    cfg(0, 4, 1, 1);
    step();
    cfg(2, 4, 0, 1);
    step();
    cfg_wr_en = 1'b0;
    req(4, 1, 1);
    step();
    in_valid = 1'b0;
    cfg(0, 4, 1, 0);
    step();
    cfg_wr_en = 1'b0;
    req(4, 0, 1);
    step();
    in_valid = 1'b0;
    cfg_clear = 1'b1;
    cfg(3, 9, 1, 1);
    step();
    cfg_clear = 1'b0;
    cfg_wr_en = 1'b0;
    req(9, 1, 1);
    step();
    req(3, 1, 0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_pending", {out_valid, in_ready}, 2'b10);
    step();
    @(negedge clk);
    chk("rst_flush", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    req(3, 0, 1);
    step();
    req(9, 0, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("sb_empty", sb.size(), 0);
    chk("miss_after_rst", miss_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
